hilo_mdu_ctrl: RTL and testbench
================================

Name: hilo_mdu_ctrl

Overview:
Multi-cycle multiply/divide controller for the HI/LO register pair of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage and holds the pipeline with a stall while an iterative shift-add or restoring-divide engine runs. On completion it presents the 64-bit result with a one-cycle HI/LO write pulse that feeds the ME-stage hiwrite/lowrite path. It also aborts cleanly on pipeline flush.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each.
ITER, 32, iteration count of the engine; must equal WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start_i  in  1  EX holds a mult/div instruction; held high while stalled.
op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
a_i  in  WIDTH  rs operand (multiplicand/dividend).
b_i  in  WIDTH  rt operand (multiplier/divisor).
annul_i  in  1  flushE/exception; aborts current op.
stall_o  out  1  pipeline stall request (combinational).
busy_o  out  1  engine not IDLE.
hi_o  out  WIDTH  HI result (remainder / upper product).
lo_o  out  WIDTH  LO result (quotient / lower product).
hilo_we_o  out  1  one-cycle write strobe for HI and LO.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, hi_o=lo_o=0, hilo_we_o=0, busy_o=0. Reset mid-operation discards the op with no write.
- States: IDLE, BUSY, DONE.
- IDLE: if start_i && !annul_i, latch op_i, |a_i|, |b_i| (absolute values for signed ops only) and result signs, clear counter -> BUSY. Cycle T0.
- BUSY: one iteration per cycle (multiply: shift-add into a 2*WIDTH accumulator; divide: restoring, one quotient bit per cycle). After ITER iterations (T1..T32) -> DONE.
- DONE (T33): hi_o/lo_o hold the final, sign-corrected result; hilo_we_o=1 for this cycle only; -> IDLE.
- stall_o = start_i && !annul_i && (state != DONE). It is high T0..T32 (33 cycles) and low at T33, so the instruction advances exactly as the write strobe fires.
- busy_o = (state != IDLE).
- hi_o/lo_o keep their last value outside DONE, and are updated only at DONE.
- Sign fix (signed ops): product is negated if sign(a) != sign(b); quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Divide by zero (b_i == 0, DIV or DIVU): lo_o = all ones, hi_o = a_i as given. Sign fix is bypassed and the full latency is still used.
- DIV 0x80000000 / 0xFFFFFFFF gives lo 0x80000000, hi 0, with no trap.
- annul_i high in any state: stall_o forced 0, next state IDLE, no hilo_we_o. If annul_i arrives in DONE, the strobe is suppressed.
- Back-to-back: a new start_i in the cycle after DONE (state IDLE) is accepted normally. There are no idle bubbles beyond the single DONE cycle.
- Operands are sampled only at T0. a_i/b_i changes during BUSY are ignored.

Decomposition:
- Package mdu_pkg: op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU, state enum (IDLE/BUSY/DONE), WIDTH default.
- Sub-module md_iter_core: iteration datapath (accumulator, shift, subtract/add, counter compare), with load/step inputs and a done flag.
- hilo_mdu_ctrl itself keeps the FSM, stall logic and sign pre/post-processing.

Test Plan:
1. MULT a=0xFFFFFFFE, b=3 -> stall_o high 33 cycles; at T33 hilo_we_o=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat as MULT -> hi=0, lo=1.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
4. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. MULT started, annul_i pulsed at T10 -> stall_o=0 that cycle, IDLE next, no hilo_we_o, hi/lo unchanged. Then DIVU 100/7 back-to-back -> lo=14, hi=2 at its T33.
6. rst driven low at T20 of a DIV -> all outputs 0 immediately. After release, MULTU 6*7 -> lo=42, hi=0 with full 33-cycle stall.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit per step.
module md_iter_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);

    localparam int CW = $clog2(ITER + 1);

    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   mul_p;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            div_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        mul_p    = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opb_q}) : {1'b0, acc_hi_q};
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opb_q});
        // When rem_ge holds the difference is below the divisor, so WIDTH bits suffice.
        rem_diff = rem_sh[WIDTH-1:0] - opb_q;

        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opb_d    = opb_q;
        div_d    = div_q;
        cnt_d    = cnt_q;

        if (load_i) begin
            acc_hi_d = '0;
            acc_lo_d = div_i ? a_i : b_i;
            opb_d    = div_i ? b_i : a_i;
            div_d    = div_i;
            cnt_d    = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CW'(1);
            if (div_q) begin
                acc_hi_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
            end else begin
                acc_hi_d = mul_p[WIDTH:1];
                acc_lo_d = {mul_p[0], acc_lo_q[WIDTH-1:1]};
            end
        end
    end

    assign hi_o   = acc_hi_q;
    assign lo_o   = acc_lo_q;
    assign last_o = (cnt_q == CW'(ITER - 1));

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide controller: FSM, pipeline stall and sign pre/post-processing.
// state | meaning
// IDLE  | waiting for start_i; operands latched on acceptance (T0)
// BUSY  | engine iterating, one bit per cycle (T1..T32)
// DONE  | result presented with one-cycle hilo_we_o (T33)
module hilo_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             hilo_we_o
);

    md_state_e state_q, state_d;
    md_op_e    op_in;

    logic             div_q, neg_res_q, neg_rem_q, dz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept;
    logic             in_signed, in_div;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic             core_last;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               commit;

    assign op_in     = md_op_e'(op_i);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);
    assign accept    = (state_q == IDLE) && start_i && !annul_i;
    assign a_abs     = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;

    md_iter_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (state_q == BUSY),
        .div_i  (in_div),
        .a_i    (a_abs),
        .b_i    (b_abs),
        .hi_o   (core_hi),
        .lo_o   (core_lo),
        .last_o (core_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                div_q     <= in_div;
                neg_res_q <= in_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                neg_rem_q <= in_signed && a_i[WIDTH-1];
                dz_q      <= in_div && (b_i == '0);
            end
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (core_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (annul_i) state_d = IDLE;
    end

    // Divide-by-zero: remainder sign fix against |a| reproduces a_i exactly.
    always_comb begin
        prod   = neg_res_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_q) begin
            res_hi = neg_rem_q ? -core_hi : core_hi;
            res_lo = dz_q ? '1 : (neg_res_q ? -core_lo : core_lo);
        end
    end

    always_comb begin
        commit    = (state_q == DONE) && !annul_i;
        stall_o   = rst && start_i && !annul_i && (state_q != DONE);
        busy_o    = (state_q != IDLE);
        hilo_we_o = commit;
        hi_o      = commit ? res_hi : hi_q;
        lo_o      = commit ? res_lo : lo_q;
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: directed ops, monitor checks every HI/LO write.
module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        annul_i = 1'b0;
    logic        stall_o, busy_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    hilo_mdu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .annul_i   (annul_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .hilo_we_o (hilo_we_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && hilo_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we: got hi=%h lo=%h with no op pending", hi_o, lo_o);
            end else begin
                chk("hilo_result", {hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    // Called just after a negedge while the DUT is IDLE; returns in the following IDLE cycle.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        exp_q.push_back({ehi, elo});
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            if (n == 5) begin
                a_i = ~a;
                b_i = b ^ 32'h0000_5A5A;
            end
            @(negedge clk);
            #1;
        end
        chk({name, "_stall_cycles"}, 64'(n), 64'd33);
        chk({name, "_we_at_T33"}, 64'(hilo_we_o), 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        #1;
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_we",    64'(hilo_we_o), 64'd0);
        chk("rst_hilo",  {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;

        do_op("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_m1m1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        do_op("div_neg7",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7_m2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op("divu_7_2",   OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3);
        do_op("divu_by0",   OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF);
        do_op("div_by0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        do_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Annul a MULT at T10.
        start_i = 1'b1;
        op_i    = OP_MULT;
        a_i     = 32'd1234;
        b_i     = 32'd5678;
        #1;
        n = 0;
        while (n < 10) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("annul_busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(stall_o), 64'd0);
        chk("annul_we",    64'(hilo_we_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        chk("annul_idle", 64'(busy_o), 64'd0);
        chk("annul_hilo_kept", {hi_o, lo_o}, {32'h0000_0000, 32'h8000_0000});

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Reset at T20 of a DIV discards it.
        start_i = 1'b1;
        op_i    = OP_DIV;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        #1;
        n = 0;
        while (n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("midrst_stall", 64'(stall_o), 64'd0);
        chk("midrst_busy",  64'(busy_o), 64'd0);
        chk("midrst_we",    64'(hilo_we_o), 64'd0);
        chk("midrst_hilo",  {hi_o, lo_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;

        do_op("multu_6_7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
